// File: rtl/rv32i_pkg.sv
// Shared RV32I write-back types: register index width, the x0 constant and
// the request record that flows through the load-result queue.
package rv32i_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  // x0 is hardwired to zero: never written and never tracked as pending.
  function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Load-result handshake between the load unit (master) and the write-back stage (slave).
// A transfer happens on a rising edge where ld_valid && ld_ready; ld_valid and its payload hold until then, and ld_ready never looks at ld_valid.
interface writeback_unit_if;
  import rv32i_pkg::*;

  logic                 ld_valid;
  logic                 ld_ready;
  logic [REG_IDX_W-1:0] ld_rd;
  logic [XLEN-1:0]      ld_data;

  modport master (output ld_valid, ld_rd, ld_data, input ld_ready);
  modport slave  (input ld_valid, ld_rd, ld_data, output ld_ready);

endinterface

// File: rtl/writeback_unit_load_fifo.sv
// Small circular FIFO holding load results until the write port is free.
// The head entry is presented combinationally; pop consumes it at the next edge.
module wb_load_fifo
  import rv32i_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  T                 i_data,
  input  logic             i_pop,
  output T                 o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Guarded locally so a misbehaving caller cannot corrupt the count.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset: a zero count already hides every stale entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage feeding the register-file write port: ALU results win the
// port, queued load results fill idle cycles, and a scoreboard tracks pending rds.
module writeback_unit #(
  parameter int XLEN      = rv32i_pkg::XLEN,
  parameter int NREG      = rv32i_pkg::NREG,
  parameter int LDQ_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           iss_valid,
  input  logic [rv32i_pkg::REG_IDX_W-1:0] iss_rd,
  input  logic [rv32i_pkg::REG_IDX_W-1:0] rs1_addr,
  input  logic [rv32i_pkg::REG_IDX_W-1:0] rs2_addr,
  output logic                           rs1_busy,
  output logic                           rs2_busy,
  input  logic                           alu_valid,
  input  logic [rv32i_pkg::REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                alu_data,
  writeback_unit_if.slave                ld,
  output logic                           WE3,
  output logic [rv32i_pkg::REG_IDX_W-1:0] address3,
  output logic [XLEN-1:0]                WD3,
  output logic [NREG-1:0]                busy_vec
);
  import rv32i_pkg::*;

  localparam int CNT_W = $clog2(LDQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(LDQ_DEPTH);

  wb_req_t              w_ld_req;
  wb_req_t              w_head;
  wb_req_t              w_sel;
  logic                 w_sel_valid;
  logic                 w_write;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [NREG-1:0]      w_busy_next;

  logic                 r_we3;
  logic [REG_IDX_W-1:0] r_address3;
  logic [XLEN-1:0]      r_wd3;
  logic [NREG-1:0]      r_busy;

  // ---------------------------------------------------------------- load queue
  assign w_ld_req.rd   = ld.ld_rd;
  assign w_ld_req.data = ld.ld_data;
  assign ld.ld_ready   = (w_count < CNT_DEPTH);
  assign w_push        = ld.ld_valid && !w_full;

  wb_load_fifo #(
    .DEPTH (LDQ_DEPTH),
    .T     (wb_req_t)
  ) u_ldq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_ld_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ---------------------------------------------------------------- arbiter
  // ALU results cannot wait, so they always take the port; loads fill gaps.
  assign w_pop = !alu_valid && !w_empty;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel.rd    = alu_rd;
      w_sel.data  = alu_data;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel       = w_head;
    end
  end

  // A result aimed at x0 is consumed silently; the port keeps its last index/data.
  assign w_write = w_sel_valid && !is_zero_reg(w_sel.rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we3      <= 1'b0;
      r_address3 <= '0;
      r_wd3      <= '0;
    end else begin
      r_we3 <= w_write;
      if (w_write) begin
        r_address3 <= w_sel.rd;
        r_wd3      <= w_sel.data;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  // Clear lands on the edge the register file captures; a same-edge reissue wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_we3) begin
      w_busy_next[r_address3] = 1'b0;
    end
    if (iss_valid && !is_zero_reg(iss_rd)) begin
      w_busy_next[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign rs1_busy = r_busy[rs1_addr] && !is_zero_reg(rs1_addr);
  assign rs2_busy = r_busy[rs2_addr] && !is_zero_reg(rs2_addr);

  assign WE3      = r_we3;
  assign address3 = r_address3;
  assign WD3      = r_wd3;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU path, contention with the load
// queue, x0 handling, scoreboard set/clear collision and asynchronous reset mid-drain.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        WE3;
  logic [4:0]  address3;
  logic [31:0] WD3;
  logic [31:0] busy_vec;

  int checks;
  int errors;

  writeback_unit_if ld_if ();

  writeback_unit #(
    .XLEN      (32),
    .NREG      (32),
    .LDQ_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld        (ld_if),
    .WE3       (WE3),
    .address3  (address3),
    .WD3       (WD3),
    .busy_vec  (busy_vec)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1 unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_rd    = rd;
    tick();
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_rd    = 5'd3;
    ld_if.ld_data  = 32'h33;
    repeat (3) tick();
    checks++;
    if ({WE3, address3, WD3} !== 38'd0) begin
      errors++;
      $display("FAIL reset_port: got %b/%0d/%h expected 0/0/0", WE3, address3, WD3);
    end
    checks++;
    if (ld_if.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ld_ready: got %b expected 1", ld_if.ld_ready);
    end
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL reset_busy: got %h expected 0", busy_vec);
    end
    ld_if.ld_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (WE3 !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_we3 cycle %0d: got %b expected 0", i, WE3);
      end
    end
  endtask

  task automatic test_alu_path();
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    issue(5'd5);
    checks++;
    if ({busy_vec, rs1_busy, rs2_busy} !== {32'h0000_0020, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL alu_issue_busy: got %h/%b/%b expected 00000020/1/0", busy_vec, rs1_busy, rs2_busy);
    end
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({WE3, rs1_busy} !== 2'b01) begin
      errors++;
      $display("FAIL alu_pre_edge: got we3=%b rs1_busy=%b expected 0/1", WE3, rs1_busy);
    end
    tick();
    alu_valid = 1'b0;
    checks++;
    if ({WE3, address3, WD3, rs1_busy} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1}) begin
      errors++;
      $display("FAIL alu_write: got %b/%0d/%h busy=%b expected 1/5/deadbeef busy=1", WE3, address3, WD3, rs1_busy);
    end
    tick();
    checks++;
    if ({WE3, address3, WD3, busy_vec, rs1_busy} !== {1'b0, 5'd5, 32'hDEAD_BEEF, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL alu_after: got %b/%0d/%h busy=%h rs1=%b expected 0/5/deadbeef busy=0 rs1=0",
               WE3, address3, WD3, busy_vec, rs1_busy);
    end
  endtask

  task automatic test_contention();
    logic [4:0]  rds [6];
    logic [4:0]  alu_rds [3];
    logic [4:0]  ld_rds [3];
    logic [2:0]  exp_ready [3];
    rds       = '{5'd7, 5'd8, 5'd10, 5'd1, 5'd2, 5'd3};
    alu_rds   = '{5'd1, 5'd2, 5'd3};
    ld_rds    = '{5'd7, 5'd8, 5'd10};
    exp_ready = '{3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 6; i++) issue(rds[i]);
    checks++;
    if (busy_vec !== 32'h0000_058E) begin
      errors++;
      $display("FAIL cont_busy_issue: got %h expected 0000058e", busy_vec);
    end
    // Three cycles of ALU and load offered together; ALU takes the port each time.
    for (int i = 0; i < 3; i++) begin
      alu_valid      = 1'b1;
      alu_rd         = alu_rds[i];
      alu_data       = 32'hA0 + 32'(i + 1);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_rd    = ld_rds[i];
      ld_if.ld_data  = 32'(ld_rds[i]);
      checks++;
      if (ld_if.ld_ready !== exp_ready[i][0]) begin
        errors++;
        $display("FAIL cont_ready cycle %0d: got %b expected %b", i, ld_if.ld_ready, exp_ready[i][0]);
      end
      tick();
      checks++;
      if ({WE3, address3, WD3} !== {1'b1, alu_rds[i], 32'hA0 + 32'(i + 1)}) begin
        errors++;
        $display("FAIL cont_alu cycle %0d: got %b/%0d/%h expected 1/%0d/%h",
                 i, WE3, address3, WD3, alu_rds[i], 32'hA0 + 32'(i + 1));
      end
    end
    alu_valid = 1'b0;
    checks++;
    if (ld_if.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL cont_full_ready: got %b expected 0", ld_if.ld_ready);
    end
    tick();
    checks++;
    if ({WE3, address3, WD3, ld_if.ld_ready} !== {1'b1, 5'd7, 32'h7, 1'b1}) begin
      errors++;
      $display("FAIL cont_ld7: got %b/%0d/%h ready=%b expected 1/7/7 ready=1", WE3, address3, WD3, ld_if.ld_ready);
    end
    tick();
    ld_if.ld_valid = 1'b0;
    checks++;
    if ({WE3, address3, WD3} !== {1'b1, 5'd8, 32'h8}) begin
      errors++;
      $display("FAIL cont_ld8: got %b/%0d/%h expected 1/8/8", WE3, address3, WD3);
    end
    tick();
    checks++;
    if ({WE3, address3, WD3} !== {1'b1, 5'd10, 32'hA}) begin
      errors++;
      $display("FAIL cont_ld10: got %b/%0d/%h expected 1/10/a", WE3, address3, WD3);
    end
    tick();
    checks++;
    if ({WE3, busy_vec, ld_if.ld_ready} !== {1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL cont_idle: got we3=%b busy=%h ready=%b expected 0/0/1", WE3, busy_vec, ld_if.ld_ready);
    end
  endtask

  task automatic test_x0();
    iss_valid      = 1'b1;
    iss_rd         = 5'd0;
    alu_valid      = 1'b1;
    alu_rd         = 5'd0;
    alu_data       = 32'h1234;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_rd    = 5'd0;
    ld_if.ld_data  = 32'h5555;
    tick();
    iss_valid      = 1'b0;
    alu_valid      = 1'b0;
    ld_if.ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({WE3, busy_vec} !== {1'b0, 32'd0}) begin
        errors++;
        $display("FAIL x0_no_write cycle %0d: got we3=%b busy=%h expected 0/0", i, WE3, busy_vec);
      end
      tick();
    end
    // A drained queue lets a fresh load reach the port one edge after its push.
    issue(5'd4);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_rd    = 5'd4;
    ld_if.ld_data  = 32'h44;
    tick();
    ld_if.ld_valid = 1'b0;
    checks++;
    if (WE3 !== 1'b0) begin
      errors++;
      $display("FAIL x0_push_edge: got %b expected 0", WE3);
    end
    tick();
    checks++;
    if ({WE3, address3, WD3} !== {1'b1, 5'd4, 32'h44}) begin
      errors++;
      $display("FAIL x0_drained: got %b/%0d/%h expected 1/4/44", WE3, address3, WD3);
    end
    tick();
  endtask

  task automatic test_collision();
    issue(5'd9);
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h99;
    tick();
    alu_valid = 1'b0;
    checks++;
    if ({WE3, address3, WD3} !== {1'b1, 5'd9, 32'h99}) begin
      errors++;
      $display("FAIL coll_write: got %b/%0d/%h expected 1/9/99", WE3, address3, WD3);
    end
    issue(5'd9);
    checks++;
    if ({WE3, busy_vec} !== {1'b0, 32'h0000_0200}) begin
      errors++;
      $display("FAIL coll_set_wins: got we3=%b busy=%h expected 0/00000200", WE3, busy_vec);
    end
    alu_valid = 1'b1;
    alu_data  = 32'h999;
    tick();
    alu_valid = 1'b0;
    checks++;
    if ({WE3, address3, WD3} !== {1'b1, 5'd9, 32'h999}) begin
      errors++;
      $display("FAIL coll_second_write: got %b/%0d/%h expected 1/9/999", WE3, address3, WD3);
    end
    tick();
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL coll_clear: got %h expected 0", busy_vec);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 12; i < 16; i++) issue(5'(i));
    alu_valid      = 1'b1;
    alu_rd         = 5'd14;
    alu_data       = 32'hE;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_rd    = 5'd12;
    ld_if.ld_data  = 32'hC;
    tick();
    alu_rd         = 5'd15;
    alu_data       = 32'hF;
    ld_if.ld_rd    = 5'd13;
    ld_if.ld_data  = 32'hD;
    tick();
    alu_valid      = 1'b0;
    ld_if.ld_valid = 1'b0;
    checks++;
    if ({WE3, address3, WD3, ld_if.ld_ready} !== {1'b1, 5'd15, 32'hF, 1'b0}) begin
      errors++;
      $display("FAIL ar_fill: got %b/%0d/%h ready=%b expected 1/15/f ready=0", WE3, address3, WD3, ld_if.ld_ready);
    end
    tick();
    checks++;
    if ({WE3, address3, WD3} !== {1'b1, 5'd12, 32'hC}) begin
      errors++;
      $display("FAIL ar_ld12: got %b/%0d/%h expected 1/12/c", WE3, address3, WD3);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({WE3, address3, WD3, busy_vec, ld_if.ld_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL ar_immediate: got %b/%0d/%h busy=%h ready=%b expected 0/0/0 busy=0 ready=1",
               WE3, address3, WD3, busy_vec, ld_if.ld_ready);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({WE3, busy_vec} !== {1'b0, 32'd0}) begin
        errors++;
        $display("FAIL ar_no_stale cycle %0d: got we3=%b addr=%0d busy=%h expected 0/busy 0", i, WE3, address3, busy_vec);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    checks         = 0;
    errors         = 0;
    iss_valid      = 1'b0;
    iss_rd         = 5'd0;
    rs1_addr       = 5'd0;
    rs2_addr       = 5'd0;
    alu_valid      = 1'b0;
    alu_rd         = 5'd0;
    alu_data       = 32'd0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_rd    = 5'd0;
    ld_if.ld_data  = 32'd0;
    test_reset();
    test_alu_path();
    test_contention();
    test_x0();
    test_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
